// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C command sequencer: FSM states, the 16-bit command
// word and the read/write direction constants.
package i2c_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_RESP
    } seq_state_t;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
    } i2c_cmd_t;

    localparam logic I2C_RD = 1'b1;
    localparam logic I2C_WR = 1'b0;

endpackage

// File: rtl/i2c_seq_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and
// empty fall out of a plain pointer difference.
module i2c_seq_fifo
    import i2c_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  i2c_cmd_t                 wdata,
    output i2c_cmd_t                 rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    i2c_cmd_t    mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == FULL_LEVEL);
    assign empty = (wr_ptr == rd_ptr);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C commands and paces them onto an i2c_controller master one at a
// time, returning read bytes on a valid/ready port. Optional: I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [6:0]               cmd_addr,
    input  logic                     cmd_rw,
    input  logic [7:0]               cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [6:0]               m_addr,
    output logic [7:0]               m_data_in,
    output logic                     m_rw,
    output logic                     m_enable,
    input  logic                     m_ready,
    input  logic [7:0]               m_data_out
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
        $error("i2c_cmd_sequencer: DEPTH must be a power of two >= 2, TIMEOUT >= 2");
    end

    seq_state_t state;
    i2c_cmd_t   head;
    logic       full;
    logic       empty;
    logic       pop;

    i2c_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (pop),
        .wdata ({cmd_addr, cmd_rw, cmd_data}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign cmd_ready = !full;
    assign busy      = !empty || (state != ST_IDLE);
    assign pop       = (state == ST_IDLE) && !empty && m_ready;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] phase_cnt;
    logic          rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            m_addr    <= '0;
            m_data_in <= '0;
            m_rw      <= 1'b0;
            m_enable  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
            phase_cnt <= '0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        m_addr    <= head.addr;
                        m_rw      <= head.rw;
                        m_data_in <= head.data;
                        m_enable  <= 1'b1;
                        state     <= ST_ISSUE;
`ifdef I2C_SEQ_TIMEOUT_EN
                        phase_cnt <= '0;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (!m_ready) begin
                        m_enable <= 1'b0;
                        state    <= ST_BUSY;
`ifdef I2C_SEQ_TIMEOUT_EN
                        phase_cnt <= '0;
                    end else if (phase_cnt == LAST) begin
                        m_enable  <= 1'b0;
                        rsp_err_q <= 1'b1;
                        rsp_data  <= '0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
`endif
                    end
                end
                ST_BUSY: begin
                    // Writes complete silently; only reads produce a response.
                    if (m_ready) begin
                        if (m_rw == I2C_RD) begin
                            rsp_data  <= m_data_out;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
`ifdef I2C_SEQ_TIMEOUT_EN
                            rsp_err_q <= 1'b0;
`endif
                        end else begin
                            state <= ST_IDLE;
                        end
`ifdef I2C_SEQ_TIMEOUT_EN
                    end else if (phase_cnt == LAST) begin
                        rsp_err_q <= 1'b1;
                        rsp_data  <= '0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
`endif
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
